// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into visible LED blinks with a fixed on-time
// and off-gap; events arriving mid-blink are queued and replayed as separate blinks.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 1000,
    parameter int GAP_CYCLES = 500,
    parameter int CW         = 16,
    parameter int QW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pulse_in,
    output logic          led,
    output logic          busy,
    output logic [QW-1:0] pending,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] T_ONE    = CW'(1);
    localparam logic [QW-1:0] P_ONE    = QW'(1);
    localparam logic [QW-1:0] P_MAX    = '1;

    state_t        state_q, state_d;
    logic [CW-1:0] timer_q, timer_d;
    logic [QW-1:0] pending_d;
    logic          overflow_d;
    logic          inc, dec;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
        state_d    = state_q;
        timer_d    = timer_q;
        pending_d  = pending;
        overflow_d = overflow;
        inc        = 1'b0;
        dec        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d = ON;
                    timer_d = ON_LOAD;
                end
            end
            ON: begin
                inc = pulse_in;
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end
            end
            GAP: begin
                inc = pulse_in;
                if (timer_q != '0) begin
                    timer_d = timer_q - T_ONE;
                end else if (pending != '0) begin
                    state_d = ON;
                    timer_d = ON_LOAD;
                    dec     = 1'b1;
                end else if (pulse_in) begin
                    // Empty queue at the end of the gap: this event starts the next blink itself.
                    state_d = ON;
                    timer_d = ON_LOAD;
                    inc     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        if (inc && !dec) begin
            if (pending != P_MAX) begin
                pending_d = pending + P_ONE;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (dec && !inc) begin
            pending_d = pending - P_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pending  <= pending_d;
            overflow <= overflow_d;
            led      <= (state_d == ON);
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher: directed vector table for the corner scenarios,
// then random strobes and resets checked against a blink-schedule reference model.
module tb_pulse_stretcher;

    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int CW   = 16;
    localparam int QW   = 2;
    localparam int PER  = ON + GAP;
    localparam int PMAX = (1 << QW) - 1;
    localparam int NC   = 40;
    localparam int NSC  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulse_in;
    logic          led;
    logic          busy;
    logic [QW-1:0] pending;
    logic          overflow;

    always #5 clk = ~clk;

    pulse_stretcher #(
        .ON_CYCLES (ON),
        .GAP_CYCLES(GAP),
        .CW        (CW),
        .QW        (QW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    typedef struct {
        logic rst;
        logic pulse;
        logic led;
        logic busy;
        int   pend;
        logic ovf;
    } vec_t;

    // Reference model: each accepted event becomes a scheduled blink start cycle.
    typedef struct {
        int acc;
        int s;
    } blink_t;

    vec_t   vecs[$];
    blink_t mq[$];
    bit     m_ovf = 1'b0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_expect(input int c, output logic el, output logic eb,
                                output int ep, output logic eo);
        while (mq.size() > 0 && mq[0].s + PER <= c) void'(mq.pop_front());
        el = 1'b0;
        eb = 1'b0;
        ep = 0;
        foreach (mq[i]) begin
            if (mq[i].s <= c) begin
                eb = 1'b1;
                if (c < mq[i].s + ON) el = 1'b1;
            end
            if (mq[i].s > c && mq[i].acc < c) ep++;
        end
        eo = m_ovf;
    endtask

    task automatic model_update(input int c, input logic r, input logic p);
        int start;
        int waiting;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else if (p) begin
            start = c + 1;
            if (mq.size() > 0 && mq[$].s + PER > start) start = mq[$].s + PER;
            waiting = 0;
            foreach (mq[i]) if (mq[i].s > c + 1) waiting++;
            if (start == c + 1 || waiting < PMAX) mq.push_back('{acc: c, s: start});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic p, input bit use_tab, input vec_t v,
                        input string tag);
        logic el, eb, eo;
        int   ep;
        @(negedge clk);
        model_expect(cyc, el, eb, ep, eo);
        check({tag, " model led"}, led, el);
        check({tag, " model busy"}, busy, eb);
        check({tag, " model pending"}, pending, ep);
        check({tag, " model overflow"}, overflow, eo);
        if (use_tab) begin
            check({tag, " table led"}, led, v.led);
            check({tag, " table busy"}, busy, v.busy);
            check({tag, " table pending"}, pending, v.pend);
            check({tag, " table overflow"}, overflow, v.ovf);
        end
        rst      = r;
        pulse_in = p;
        model_update(cyc, r, p);
        cyc++;
    endtask

    function automatic bit rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic bit pulse_at(input int s, input int c);
        case (s)
            0:       return c == 10;
            1:       return c == 10 || rng(c, 12, 14);
            2:       return rng(c, 10, 15);
            3:       return c == 10 || c == 16;
            default: return rng(c, 10, 12) || c == 20;
        endcase
    endfunction

    string sc_name[NSC] = '{"single", "queue", "saturate", "lastgap", "rstmid"};

    initial begin
        vec_t v;
        vec_t dummy;
        int   dens;

        dummy.rst = 1'b0; dummy.pulse = 1'b0; dummy.led = 1'b0;
        dummy.busy = 1'b0; dummy.pend = 0; dummy.ovf = 1'b0;

        // Every scenario opens with 3 reset cycles while pulse_in toggles.
        for (int s = 0; s < NSC; s++) begin
            for (int c = 0; c < NC; c++) begin
                v.rst   = (c < 3) || (s == 4 && c == 13);
                v.pulse = (c < 3) ? logic'(c % 2 == 1) : logic'(pulse_at(s, c));
                v.ovf   = 1'b0;
                v.pend  = 0;
                case (s)
                    0: begin
                        v.led  = rng(c, 11, 14);
                        v.busy = rng(c, 11, 16);
                    end
                    1, 2: begin
                        v.led  = rng(c, 11, 14) || rng(c, 17, 20) || rng(c, 23, 26) || rng(c, 29, 32);
                        v.busy = rng(c, 11, 34);
                        if (s == 1) begin
                            if (c == 13) v.pend = 1;
                            else if (c == 14) v.pend = 2;
                        end else begin
                            if (c == 12) v.pend = 1;
                            else if (c == 13) v.pend = 2;
                            else if (c == 14) v.pend = 3;
                            v.ovf = (c >= 15);
                        end
                        if (rng(c, 15, 16)) v.pend = 3;
                        else if (rng(c, 17, 22)) v.pend = 2;
                        else if (rng(c, 23, 28)) v.pend = 1;
                    end
                    3: begin
                        v.led  = rng(c, 11, 14) || rng(c, 17, 20);
                        v.busy = rng(c, 11, 22);
                    end
                    default: begin
                        v.led  = rng(c, 11, 13) || rng(c, 21, 24);
                        v.busy = rng(c, 11, 13) || rng(c, 21, 26);
                        if (c == 12) v.pend = 1;
                        else if (c == 13) v.pend = 2;
                    end
                endcase
                vecs.push_back(v);
            end
        end

        rst      = 1'b1;
        pulse_in = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].pulse, (i % NC) >= 1, vecs[i], sc_name[i / NC]);
        end

        // Random phase: bursts of varying density with occasional resets.
        for (int b = 0; b < 30; b++) begin
            dens = $urandom_range(5, 80);
            for (int c = 0; c < 100; c++) begin
                step(logic'($urandom_range(0, 299) == 0),
                     logic'($urandom_range(0, 99) < dens), 1'b0, dummy, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
